// File: rtl/mem_arb_pkg.sv
// Shared encodings for the unified-memory port arbiter: FSM states and grant ids.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ACK   = 2'd3
    } arb_state_t;

    localparam logic GNT_IF = 1'b0;
    localparam logic GNT_D  = 1'b1;

    localparam int CNT_W = 4;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one single-port, fixed-latency memory between the IF fetch port and the
// MEM load/store port; one access in flight, round-robin on ties, fetch flush support.
//
// state | meaning
// IDLE  | no access in flight; requests sampled and arbitrated
// ISSUE | mem_cs strobe for the granted access
// WAIT  | LAT cycles for read data; data captured in the last one
// ACK   | one-cycle ack to the granted port (fetch ack suppressed if killed)
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LAT    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_wen,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_cs,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              busy
);

    if (LAT < 1 || LAT > 15) begin : g_lat_range
        $error("mem_port_arbiter: LAT must be within 1..15");
    end

    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LAT - 1);

    arb_state_t        state_q, state_d;
    logic              last_gnt_q, last_gnt_d;
    logic              gnt_q, gnt_d;
    logic              kill_q, kill_d;
    logic              wen_q, wen_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              mem_cs_q, mem_cs_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_din_q, mem_din_d;
    logic              if_ack_q, if_ack_d;
    logic              d_ack_q, d_ack_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              busy_q, busy_d;
    logic              pick_d;

    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        gnt_d      = gnt_q;
        kill_d     = kill_q;
        wen_d      = wen_q;
        cnt_d      = cnt_q;
        mem_cs_d   = 1'b0;
        mem_we_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        if_ack_d   = 1'b0;
        d_ack_d    = 1'b0;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        pick_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (if_req || d_req) begin
                    // Data wins when alone, or on a tie if fetch was served last.
                    pick_d     = d_req && (!if_req || (last_gnt_q == GNT_IF));
                    gnt_d      = pick_d ? GNT_D : GNT_IF;
                    last_gnt_d = gnt_d;
                    if (pick_d) begin
                        mem_addr_d = d_addr;
                        mem_din_d  = d_wdata;
                        wen_d      = d_wen;
                    end else begin
                        mem_addr_d = if_addr;
                        mem_din_d  = '0;
                        wen_d      = 1'b0;
                    end
                    mem_cs_d = 1'b1;
                    mem_we_d = wen_d;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if ((gnt_q == GNT_IF) && if_flush) kill_d = 1'b1;
                cnt_d   = LAT_M1;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if ((gnt_q == GNT_IF) && if_flush) kill_d = 1'b1;
                if (cnt_q == '0) begin
                    state_d = ST_ACK;
                    if (gnt_q == GNT_IF) begin
                        if_rdata_d = mem_dout;
                        if_ack_d   = !(kill_q || if_flush);
                    end else begin
                        if (!wen_q) d_rdata_d = mem_dout;
                        d_ack_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_ACK: begin
                if ((gnt_q == GNT_IF) && if_flush) kill_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d == ST_IDLE) kill_d = 1'b0;
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            last_gnt_q <= GNT_IF;
            gnt_q      <= GNT_IF;
            kill_q     <= 1'b0;
            wen_q      <= 1'b0;
            cnt_q      <= '0;
            mem_cs_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            if_ack_q   <= 1'b0;
            d_ack_q    <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            gnt_q      <= gnt_d;
            kill_q     <= kill_d;
            wen_q      <= wen_d;
            cnt_q      <= cnt_d;
            mem_cs_q   <= mem_cs_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
            if_ack_q   <= if_ack_d;
            d_ack_q    <= d_ack_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
            busy_q     <= busy_d;
        end
    end

    assign if_ack   = if_ack_q;
    assign d_ack    = d_ack_q;
    assign if_rdata = if_rdata_q;
    assign d_rdata  = d_rdata_q;
    assign mem_cs   = mem_cs_q;
    assign mem_we   = mem_we_q;
    assign mem_addr = mem_addr_q;
    assign mem_din  = mem_din_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a LAT=1 instance for the main traffic and a
// LAT=4 instance for reset-in-WAIT behaviour, each with a small fixed-latency memory model.
module tb_mem_port_arbiter;

    localparam int L1 = 1;
    localparam int L4 = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rst4 = 1'b1;
    logic        if_req = 1'b0;
    logic        if_flush = 1'b0;
    logic [31:0] if_addr = '0;
    logic        d_req = 1'b0;
    logic        d_req4 = 1'b0;
    logic        d_wen = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;

    logic        if_ack, d_ack, mem_cs, mem_we, busy;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_din, mem_dout;
    logic        if_ack4, d_ack4, mem_cs4, mem_we4, busy4;
    logic [31:0] if_rdata4, d_rdata4, mem_addr4, mem_din4, mem_dout4;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LAT(L1)) u_dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout), .busy(busy)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LAT(L4)) u_dut4 (
        .clk(clk), .rst(rst4),
        .if_req(1'b0), .if_addr(32'h0), .if_flush(1'b0),
        .if_ack(if_ack4), .if_rdata(if_rdata4),
        .d_req(d_req4), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack4), .d_rdata(d_rdata4),
        .mem_cs(mem_cs4), .mem_we(mem_we4), .mem_addr(mem_addr4), .mem_din(mem_din4),
        .mem_dout(mem_dout4), .busy(busy4)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] rd1(input logic [31:0] a);
        return (a == 32'h10) ? 32'hDEADBEEF : {a[15:0], 16'h5A5A};
    endfunction

    function automatic logic [31:0] rd4(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // Read data is valid only exactly LAT cycles after the mem_cs cycle.
    logic        dl1_v = 1'b0;
    logic [31:0] dl1_d = '0;
    always @(posedge clk) begin
        dl1_v <= mem_cs && !mem_we;
        dl1_d <= rd1(mem_addr);
    end
    assign mem_dout = dl1_v ? dl1_d : 32'hBAD0BAD0;

    logic [3:0]  dl4_v = '0;
    logic [31:0] dl4_d [4];
    always @(posedge clk) begin
        dl4_v    <= {dl4_v[2:0], mem_cs4 && !mem_we4};
        dl4_d[0] <= rd4(mem_addr4);
        for (int i = 1; i < 4; i++) dl4_d[i] <= dl4_d[i-1];
    end
    assign mem_dout4 = dl4_v[3] ? dl4_d[3] : 32'hBAD0BAD0;

    typedef struct {
        bit          is_if;
        int          cyc;
        logic [31:0] data;
        bit          chk_data;
    } ack_t;

    typedef struct {
        int          cyc;
        bit          we;
        logic [31:0] addr;
        logic [31:0] din;
        bit          chk_din;
    } cs_t;

    ack_t ack_q[$];
    cs_t  cs_q[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic exp_ack(input bit is_if, input int c, input logic [31:0] data, input bit cd);
        ack_t e;
        e = '{is_if, c, data, cd};
        ack_q.push_back(e);
    endtask

    task automatic exp_cs(input int c, input bit we, input logic [31:0] addr,
                          input logic [31:0] din, input bit cd);
        cs_t e;
        e = '{c, we, addr, din, cd};
        cs_q.push_back(e);
    endtask

    task automatic monitor();
        ack_t a;
        cs_t  c;
        forever begin
            @(negedge clk);
            if (if_ack || d_ack) begin
                if (ack_q.size() == 0) begin
                    chk("spurious_ack", {30'd0, if_ack, d_ack}, 32'd0);
                end else begin
                    a = ack_q.pop_front();
                    chk("ack_port", {30'd0, if_ack, d_ack}, a.is_if ? 32'd2 : 32'd1);
                    chk("ack_cycle", 32'(cyc), 32'(a.cyc));
                    if (a.chk_data) chk("ack_rdata", a.is_if ? if_rdata : d_rdata, a.data);
                end
            end
            if (mem_cs) begin
                if (cs_q.size() == 0) begin
                    chk("spurious_cs", {31'd0, mem_cs}, 32'd0);
                end else begin
                    c = cs_q.pop_front();
                    chk("cs_cycle", 32'(cyc), 32'(c.cyc));
                    chk("cs_we", {31'd0, mem_we}, {31'd0, c.we});
                    chk("cs_addr", mem_addr, c.addr);
                    if (c.chk_din) chk("cs_din", mem_din, c.din);
                end
            end
        end
    endtask

    task automatic hold_until_ack(input bit is_if, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (is_if ? if_ack : d_ack) seen = 1'b1;
        end
        if (is_if) begin
            if_req = 1'b0;
            chk("if_ack_seen", {31'd0, seen}, 32'd1);
        end else begin
            d_req = 1'b0;
            chk("d_ack_seen", {31'd0, seen}, 32'd1);
        end
    endtask

    task automatic wait_idle(input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (!busy) ok = 1'b1;
        end
        chk("idle_reached", {31'd0, ok}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int n;
    int r;
    int acks;
    bit any;
    bit seen;

    initial begin
        fork
            monitor();
        join_none

        repeat (3) @(negedge clk);
        chk("rst_ctl", {27'd0, if_ack, d_ack, mem_cs, mem_we, busy}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_din", mem_din, 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        chk("rst4_ctl", {27'd0, if_ack4, d_ack4, mem_cs4, mem_we4, busy4}, 32'd0);
        rst  = 1'b0;
        rst4 = 1'b0;

        // Single load.
        @(negedge clk);
        n = cyc;
        d_req = 1'b1; d_wen = 1'b0; d_addr = 32'h10; d_wdata = 32'h0;
        exp_cs(n + 1, 1'b0, 32'h10, 32'h0, 1'b1);
        exp_ack(1'b0, n + 2 + L1, 32'hDEADBEEF, 1'b1);
        hold_until_ack(1'b0, 20);
        wait_idle(10);

        // Store, then a load elsewhere.
        @(negedge clk);
        n = cyc;
        d_req = 1'b1; d_wen = 1'b1; d_addr = 32'h20; d_wdata = 32'h12345678;
        exp_cs(n + 1, 1'b1, 32'h20, 32'h12345678, 1'b1);
        exp_ack(1'b0, n + 2 + L1, 32'h0, 1'b0);
        hold_until_ack(1'b0, 20);
        d_wen = 1'b0;
        wait_idle(10);
        @(negedge clk);
        n = cyc;
        d_req = 1'b1; d_addr = 32'h24; d_wdata = 32'h0;
        exp_cs(n + 1, 1'b0, 32'h24, 32'h0, 1'b1);
        exp_ack(1'b0, n + 2 + L1, rd1(32'h24), 1'b1);
        hold_until_ack(1'b0, 20);
        wait_idle(10);

        // Simultaneous requests raised during the last reset cycle: data first.
        @(negedge clk);
        rst = 1'b1;
        r = cyc;
        if_req = 1'b1; if_addr = 32'h40;
        d_req = 1'b1; d_wen = 1'b0; d_addr = 32'h30; d_wdata = 32'h0;
        exp_cs(r + 2, 1'b0, 32'h30, 32'h0, 1'b1);
        exp_cs(r + 5 + L1, 1'b0, 32'h40, 32'h0, 1'b0);
        exp_ack(1'b0, r + 3 + L1, rd1(32'h30), 1'b1);
        exp_ack(1'b1, r + 6 + 2 * L1, rd1(32'h40), 1'b1);
        @(negedge clk);
        rst = 1'b0;
        fork
            hold_until_ack(1'b1, 40);
            hold_until_ack(1'b0, 40);
        join
        wait_idle(10);

        // Fetch flushed during WAIT: access happens, no ack.
        @(negedge clk);
        n = cyc;
        if_req = 1'b1; if_addr = 32'h44;
        exp_cs(n + 1, 1'b0, 32'h44, 32'h0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        if_flush = 1'b1; if_req = 1'b0;
        @(negedge clk);
        if_flush = 1'b0;
        chk("flush_busy_ack", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("flush_busy_idle", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);

        // Next fetch, with a flush pulse in IDLE that must be ignored.
        n = cyc;
        if_req = 1'b1; if_addr = 32'h48; if_flush = 1'b1;
        exp_cs(n + 1, 1'b0, 32'h48, 32'h0, 1'b0);
        exp_ack(1'b1, n + 2 + L1, rd1(32'h48), 1'b1);
        @(negedge clk);
        if_flush = 1'b0;
        hold_until_ack(1'b1, 20);
        wait_idle(10);

        // Continuous requests on both ports from reset: D, IF, D, IF, ...
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n = cyc;
        d_req = 1'b1; d_wen = 1'b0; d_addr = 32'h14; d_wdata = 32'h0;
        if_req = 1'b1; if_addr = 32'h18;
        for (int k = 0; k < 6; k++) begin
            exp_cs(n + 1 + k * (L1 + 3), 1'b0, (k % 2 == 1) ? 32'h18 : 32'h14, 32'h0, (k % 2 == 0));
            exp_ack((k % 2 == 1), n + 2 + L1 + k * (L1 + 3),
                    rd1((k % 2 == 1) ? 32'h18 : 32'h14), 1'b1);
        end
        acks = 0;
        for (int i = 0; i < 100 && acks < 6; i++) begin
            @(negedge clk);
            if (if_ack || d_ack) acks++;
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        chk("alt_ack_count", 32'(acks), 32'd6);
        wait_idle(10);

        // LAT=4 instance: reset in WAIT abandons the access.
        @(negedge clk);
        n = cyc;
        d_req4 = 1'b1; d_wen = 1'b0; d_addr = 32'h100; d_wdata = 32'h0;
        @(negedge clk);
        chk("r4_cs_issue", {31'd0, mem_cs4}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        chk("r4_busy_wait", {31'd0, busy4}, 32'd1);
        rst4 = 1'b1;
        @(negedge clk);
        rst4 = 1'b0;
        d_req4 = 1'b0;
        chk("r4_ctl_zero", {27'd0, if_ack4, d_ack4, mem_cs4, mem_we4, busy4}, 32'd0);
        chk("r4_addr_zero", mem_addr4, 32'd0);
        chk("r4_din_zero", mem_din4, 32'd0);
        chk("r4_rdata_zero", d_rdata4, 32'd0);
        any = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (d_ack4 || if_ack4) any = 1'b1;
        end
        chk("r4_no_ack", {31'd0, any}, 32'd0);

        n = cyc;
        d_req4 = 1'b1; d_addr = 32'h104;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (d_ack4) begin
                seen = 1'b1;
                chk("r4_ack_cycle", 32'(cyc), 32'(n + 2 + L4));
                chk("r4_rdata", d_rdata4, rd4(32'h104));
            end
        end
        d_req4 = 1'b0;
        chk("r4_ack_seen", {31'd0, seen}, 32'd1);

        repeat (4) @(negedge clk);
        chk("ack_q_drained", 32'(ack_q.size()), 32'd0);
        chk("cs_q_drained", 32'(cs_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
